// File: rtl/memtest_pkg.sv
// Shared types and constants for the Avalon-MM memory test master:
// FSM state encoding, Galois LFSR taps and the outstanding-read counter width.
package memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            64:      return 64'hD800_0000_0000_0000;
            default: return {32'h0, LFSR_TAPS_32};
        endcase
    endfunction

    // Counter must hold the value MAX_PEND itself.
    function automatic int pend_w(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Test pattern generator: load a seed, step once per word.
// MEMTEST_LFSR_EN selects a Galois LFSR (seed 0 forced to 1); otherwise seed + word_index.
module memtest_pattern_gen
    import memtest_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              step,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] word_q, word_d;

`ifdef MEMTEST_LFSR_EN
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = (seed == '0) ? DATA_W'(1) : seed;
        end else if (step) begin
            word_d = word_q[0] ? ((word_q >> 1) ^ TAPS) : (word_q >> 1);
        end
    end
`else
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = seed;
        end else if (step) begin
            word_d = word_q + DATA_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/avalon_mm_memtest_master.sv
// Avalon-MM master that fills a word region with a pattern, reads it back pipelined and
// counts mismatches. Pattern type selected by MEMTEST_LFSR_EN (see memtest_pattern_gen).
module avalon_mm_memtest_master
    import memtest_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len_words,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam int BE_W   = DATA_W / 8;
    localparam int PEND_W = pend_w(MAX_PEND);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BE_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PEND);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d, first_err_q, first_err_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, err_q, err_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [PEND_W-1:0]   pend_q, pend_d;

    logic                wr_acc, rd_acc, rdv_ok, last_cmd, slot_free;
    logic                wgen_load, rgen_load;
    logic [DATA_W-1:0]   wgen_seed, wr_word, exp_word;
    logic [ADDR_W-1:0]   base_aligned;

    assign base_aligned = base_addr & ALIGN_MASK;
    // A response with nothing outstanding is stray and must not disturb the compare side.
    assign rdv_ok    = avm_readdatavalid && (pend_q != '0);
    assign slot_free = (pend_q - PEND_W'(rdv_ok)) < PEND_MAX;
    assign last_cmd  = (cnt_q == len_q - LEN_W'(1));

    assign avm_write      = (state_q == ST_WRITE);
    assign avm_read       = (state_q == ST_READ) && slot_free;
    assign avm_address    = addr_q;
    assign avm_writedata  = wr_word;
    assign avm_byteenable = (avm_read || avm_write) ? {BE_W{1'b1}} : {BE_W{1'b0}};
    assign wr_acc         = avm_write && !avm_waitrequest;
    assign rd_acc         = avm_read && !avm_waitrequest;

    assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;

    assign pend_d = pend_q + PEND_W'(rd_acc) - PEND_W'(rdv_ok);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        rsp_addr_d  = rsp_addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        wgen_load   = 1'b0;
        wgen_seed   = seed_q;
        rgen_load   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    base_d      = base_aligned;
                    addr_d      = base_aligned;
                    rsp_addr_d  = base_aligned;
                    len_d       = len_words;
                    seed_d      = seed;
                    cnt_d       = '0;
                    err_d       = '0;
                    first_err_d = '0;
                    wgen_load   = 1'b1;
                    wgen_seed   = seed;
                    rgen_load   = 1'b1;
                    state_d     = (len_words == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_acc) begin
                    if (last_cmd) begin
                        state_d   = ST_READ;
                        addr_d    = base_q;
                        cnt_d     = '0;
                        wgen_load = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_STEP;
                        cnt_d  = cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (rd_acc) begin
                    addr_d = addr_q + ADDR_STEP;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (last_cmd) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pend_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Responses arrive in order, so a running address tracks the word being compared.
        if (rdv_ok) begin
            rsp_addr_d = rsp_addr_q + ADDR_STEP;
            if (avm_readdata != exp_word) begin
                if (err_q != '1) begin
                    err_d = err_q + LEN_W'(1);
                end
                if (err_q == '0) begin
                    first_err_d = rsp_addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            rsp_addr_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            rsp_addr_q  <= rsp_addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            pend_q      <= pend_d;
        end
    end

    memtest_pattern_gen #(.DATA_W(DATA_W)) u_wr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (wgen_load),
        .seed    (wgen_seed),
        .step    (wr_acc),
        .word    (wr_word)
    );

    memtest_pattern_gen #(.DATA_W(DATA_W)) u_rd_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rgen_load),
        .seed    (seed),
        .step    (rdv_ok),
        .word    (exp_word)
    );

endmodule

// File: tb/tb_avalon_mm_memtest_master.sv
// Bench for avalon_mm_memtest_master: Avalon slave model with stalls, latency and fault
// injection; expected traffic and error results come from a word-level model of the test.
module tb_avalon_mm_memtest_master;

    localparam int MAXP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len_words = '0;
    logic [31:0] seed = '0;
    logic        busy, done;
    logic [15:0] err_count;
    logic [31:0] first_err_addr, avm_address, avm_writedata;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;

    always #5 clk = ~clk;

    avalon_mm_memtest_master #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_PEND(MAXP)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .len_words         (len_words),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    typedef struct {
        logic [15:0] len;
        logic [31:0] base;
        logic [31:0] seed;
        int          wait_pct;
        int          lat;
        bit          corrupt_en;
        logic [31:0] corrupt_addr;
        bit          extra_start;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
    } vec_t;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    int checks = 0;
    int errors = 0;

    // Slave model state
    int          wait_pct = 0;
    int          lat = 1;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    logic [31:0] mem [0:255];
    wr_t         wq[$];
    logic [31:0] rq[$];
    rsp_t        rspq[$];
    int          cyc = 0, outstanding = 0, max_out = 0, viol = 0, proto_err = 0, cmd_cycles = 0;
    logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    // Word i of the pattern sequence started from seed s.
    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
`ifdef MEMTEST_LFSR_EN
        logic [31:0] x;
        x = (s == 0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
`else
        return s + 32'(i);
`endif
    endfunction

    function automatic void model_errs(input vec_t v, output logic [15:0] e, output logic [31:0] f);
        logic [31:0] a;
        e = 0;
        f = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            a = align(v.base) + 32'(4 * i);
            if (v.corrupt_en && a == v.corrupt_addr) begin
                if (e == 0) f = a;
                e++;
            end
        end
    endfunction

    // Avalon slave: drives responses/stalls at the falling edge, observes the command 1 ns later.
    always begin
        @(negedge clk);
        if (!reset_n) begin
            rspq.delete();
            outstanding = 0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cyc++;
            if (rspq.size() > 0 && rspq[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rspq[0].data;
                void'(rspq.pop_front());
                outstanding--;
            end else begin
                avm_readdatavalid = (outstanding == 0) && ($urandom_range(3) == 0);
                avm_readdata = $urandom;
            end
            avm_waitrequest = ($urandom_range(99) < wait_pct);
            #1;
            if (reset_n) begin
                if (avm_read || avm_write) cmd_cycles++;
                if (avm_read && avm_write) proto_err++;
                if ((avm_read || avm_write) && avm_byteenable !== 4'hF) proto_err++;
                if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
                    avm_address !== prev_addr || (avm_write && avm_writedata !== prev_data)))
                    viol++;
                prev_stall = (avm_read || avm_write) && avm_waitrequest;
                prev_rd = avm_read;
                prev_wr = avm_write;
                prev_addr = avm_address;
                prev_data = avm_writedata;
                if (avm_write && !avm_waitrequest) begin
                    wq.push_back('{avm_address, avm_writedata});
                    mem[avm_address[9:2]] = avm_writedata;
                end
                if (avm_read && !avm_waitrequest) begin
                    rq.push_back(avm_address);
                    rspq.push_back('{cyc + lat, mem[avm_address[9:2]] ^
                        ((corrupt_en && avm_address == corrupt_addr) ? 32'h0000_0001 : 32'h0)});
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int n, wbad, rbad;
        wait_pct = v.wait_pct;
        lat = v.lat;
        corrupt_en = v.corrupt_en;
        corrupt_addr = v.corrupt_addr;
        wq.delete();
        rq.delete();
        max_out = 0;
        viol = 0;
        proto_err = 0;
        @(negedge clk);
        base_addr = v.base;
        len_words = v.len;
        seed = v.seed;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.extra_start) begin
            repeat (3) @(negedge clk);
            base_addr = 32'h200;
            len_words = 16'd2;
            seed = 32'hABCD;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (n = 0; n < 3000 && done !== 1'b1; n++) @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_count"}, wq.size(), v.len);
        check({tag, "_rd_count"}, rq.size(), v.len);
        wbad = 0;
        rbad = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            if (i >= wq.size() || wq[i].addr !== align(v.base) + 32'(4 * i) ||
                wq[i].data !== pat(v.seed, i)) wbad++;
            if (i >= rq.size() || rq[i] !== align(v.base) + 32'(4 * i)) rbad++;
        end
        check({tag, "_wr_content"}, wbad, 0);
        check({tag, "_rd_addr"}, rbad, 0);
        check({tag, "_err_count"}, err_count, v.exp_err);
        check({tag, "_first_err_addr"}, first_err_addr, v.exp_first);
        check({tag, "_stall_hold"}, viol, 0);
        check({tag, "_protocol"}, proto_err, 0);
        check({tag, "_pend_limit"}, max_out <= MAXP, 1);
        if (v.wait_pct == 0 && v.lat >= 3 && v.len >= 2)
            check({tag, "_pend_reached"}, max_out, MAXP);
        $display("run %s len=%0d base=%h seed=%h wait=%0d lat=%0d writes=%0d reads=%0d err=%0d first=%h maxpend=%0d",
                 tag, v.len, v.base, v.seed, v.wait_pct, v.lat, wq.size(), rq.size(),
                 err_count, first_err_addr, max_out);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        bit   hit;
        int   k;

        // Directed vectors with hand-computed expectations, then randomized ones via the model.
        vecs[0] = '{16'd8, 32'h100, 32'h10, 0, 1, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0};
        vecs[1] = '{16'd8, 32'h100, 32'h10, 50, 1, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0};
        vecs[2] = '{16'd8, 32'h100, 32'h10, 0, 3, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0};
        vecs[3] = '{16'd8, 32'h100, 32'h10, 20, 2, 1'b1, 32'h10C, 1'b0, 16'd1, 32'h10C};
        vecs[4] = '{16'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 30, 2, 1'b1, 32'h4, 1'b0, 16'd1, 32'h4};
        vecs[5] = '{16'd8, 32'h180, 32'h55, 0, 2, 1'b0, 32'h0, 1'b1, 16'd0, 32'h0};
        for (int i = 6; i < 10; i++) begin
            v.len = 16'($urandom_range(1, 20));
            v.base = $urandom;
            v.seed = $urandom;
            v.wait_pct = $urandom_range(0, 60);
            v.lat = $urandom_range(1, 4);
            v.corrupt_en = ($urandom_range(1) == 1);
            v.corrupt_addr = align(v.base) + 32'(4 * $urandom_range(0, int'(v.len) - 1));
            v.extra_start = 1'b0;
            model_errs(v, v.exp_err, v.exp_first);
            vecs[i] = v;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", {err_count, first_err_addr}, 0);
        check("rst_bus", {avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}, 0);
        reset_n = 1'b1;

        // len = 0: DONE one cycle after start, no bus traffic
        cmd_cycles = 0;
        @(negedge clk);
        base_addr = 32'h100;
        len_words = 16'd0;
        seed = 32'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("len0_no_traffic", cmd_cycles, 0);
        $display("run len0 done=%0d cmd_cycles=%0d", done, cmd_cycles);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
`ifndef MEMTEST_LFSR_EN
            if (i == 0) check("v0_last_write", {wq[wq.size() - 1].addr, wq[wq.size() - 1].data},
                              {32'h11C, 32'h17});
`endif
        end

        // Reset during READ with two reads outstanding, then a clean restart
        wait_pct = 0;
        lat = 3;
        corrupt_en = 1'b0;
        @(negedge clk);
        base_addr = 32'h300;
        len_words = 16'd8;
        seed = 32'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            #2;
            hit = (outstanding == 2) && avm_read === 1'b0;
        end
        check("midrst_two_pending", hit, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_async_cmd", {avm_read, avm_write, avm_byteenable}, 0);
        check("midrst_async_status", {busy, done, err_count, first_err_addr}, 0);
        $display("run midreset pending_seen=%0d read=%0d write=%0d busy=%0d", hit, avm_read, avm_write, busy);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        v = '{16'd4, 32'h400, 32'h77, 0, 3, 1'b0, 32'h0, 1'b0, 16'd0, 32'h0};
        run_vec(v, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
